// File: rtl/mem_stage.sv
// Memory-access stage: turns the latched load/store into a single valid/ready
// bus transaction, stalls upstream until it completes, then aligns/extends load data.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_addr_i,
  input  logic        ren_i,
  input  logic [63:0] raddr_i,
  input  logic [2:0]  ld_type_i,
  input  logic        wen_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  input  logic [63:0] rd_wdata_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        reg_wen_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic        dmem_req_wen_o,
  output logic [63:0] dmem_req_addr_o,
  output logic [63:0] dmem_req_wdata_o,
  output logic [7:0]  dmem_req_wmask_o,
  input  logic        dmem_resp_valid_i,
  input  logic [63:0] dmem_resp_rdata_i,
  output logic        mem_stall_o,
  output logic        mem_err_o,
  output logic [63:0] inst_addr_o,
  output logic [63:0] rd_wdata_o,
  output logic [4:0]  rd_waddr_o,
  output logic        reg_wen_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Bus handshake: a request transfers on a cycle where valid & ready are both
  // high; valid never drops and the request fields never change until then.
  // dmem_resp_valid_i is only honoured in WAIT.

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      load_buf_q, load_buf_d;
  logic             err_q, err_d;

  logic        access;
  logic [63:0] active_addr;
  logic [63:0] shifted;
  logic [63:0] load_result;

  assign access      = wen_i | ren_i;
  assign active_addr = wen_i ? waddr_i : raddr_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_buf_d = load_buf_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (access) state_d = S_REQ;
      S_REQ: begin
        if (dmem_req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response in the final allowed cycle still wins over the abort.
        if (dmem_resp_valid_i) begin
          load_buf_d = dmem_resp_rdata_i;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          load_buf_d = '0;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      load_buf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_buf_q <= load_buf_d;
      err_q      <= err_d;
    end
  end

  assign dmem_req_valid_o = (state_q == S_REQ);
  assign dmem_req_wen_o   = wen_i;
  assign dmem_req_addr_o  = {active_addr[63:3], 3'b000};
  assign dmem_req_wdata_o = wdata_i;
  assign dmem_req_wmask_o = wen_i ? wmask_i : 8'h00;

  assign mem_stall_o = ((state_q == S_IDLE) & access) | (state_q == S_REQ) | (state_q == S_WAIT);
  assign mem_err_o   = err_q;

  // Bytes past the end of the 8-byte line shift in as zero; no line splitting.
  assign shifted = load_buf_q >> {raddr_i[2:0], 3'b000};

  always_comb begin
    case (ld_type_i)
      3'b000:  load_result = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_result = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_result = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_result = {56'd0, shifted[7:0]};
      3'b101:  load_result = {48'd0, shifted[15:0]};
      3'b110:  load_result = {32'd0, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

  assign rd_wdata_o  = ((state_q == S_DONE) & ren_i & ~wen_i) ? load_result : rd_wdata_i;
  assign reg_wen_o   = reg_wen_i & ~mem_stall_o;
  assign rd_waddr_o  = rd_waddr_i;
  assign inst_addr_o = inst_addr_i;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random load/store traffic with
// random bus latencies, compared cycle by cycle against a transaction-level model.
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_addr_i, raddr_i, waddr_i, wdata_i, rd_wdata_i, dmem_resp_rdata_i;
  logic        ren_i, wen_i, reg_wen_i, dmem_req_ready_i, dmem_resp_valid_i;
  logic [2:0]  ld_type_i;
  logic [7:0]  wmask_i;
  logic [4:0]  rd_waddr_i;
  logic        dmem_req_valid_o, dmem_req_wen_o, mem_stall_o, mem_err_o, reg_wen_o;
  logic [63:0] dmem_req_addr_o, dmem_req_wdata_o, inst_addr_o, rd_wdata_o;
  logic [7:0]  dmem_req_wmask_o;
  logic [4:0]  rd_waddr_o;

  mem_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr_i), .ren_i(ren_i), .raddr_i(raddr_i), .ld_type_i(ld_type_i),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
    .rd_wdata_i(rd_wdata_i), .rd_waddr_i(rd_waddr_i), .reg_wen_i(reg_wen_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_req_wen_o(dmem_req_wen_o), .dmem_req_addr_o(dmem_req_addr_o),
    .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_req_wmask_o(dmem_req_wmask_o),
    .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_resp_rdata_i(dmem_resp_rdata_i),
    .mem_stall_o(mem_stall_o), .mem_err_o(mem_err_o),
    .inst_addr_o(inst_addr_o), .rd_wdata_o(rd_wdata_o),
    .rd_waddr_o(rd_waddr_o), .reg_wen_o(reg_wen_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- expected-output record per cycle ----------------
  typedef struct {
    logic        stall;
    logic        reqv;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        err;
    logic [63:0] rd;
    logic        reg_wen;
    logic [4:0]  rd_waddr;
    logic [63:0] inst_addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [63:0] mem_model [logic [60:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard: one compare per cycle ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_stall_o", 64'(mem_stall_o), 64'(e.stall));
      chk("dmem_req_valid_o", 64'(dmem_req_valid_o), 64'(e.reqv));
      chk("mem_err_o", 64'(mem_err_o), 64'(e.err));
      chk("rd_wdata_o", rd_wdata_o, e.rd);
      chk("reg_wen_o", 64'(reg_wen_o), 64'(e.reg_wen));
      chk("rd_waddr_o", 64'(rd_waddr_o), 64'(e.rd_waddr));
      chk("inst_addr_o", inst_addr_o, e.inst_addr);
      if (e.reqv) begin
        chk("dmem_req_wen_o", 64'(dmem_req_wen_o), 64'(e.req_wen));
        chk("dmem_req_addr_o", dmem_req_addr_o, e.req_addr);
        chk("dmem_req_wdata_o", dmem_req_wdata_o, e.req_wdata);
        chk("dmem_req_wmask_o", 64'(dmem_req_wmask_o), 64'(e.req_wmask));
      end
    end
  end

  // ---------------- behavioural model helpers ----------------
  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] mem_get(input logic [60:0] line_idx);
    if (!mem_model.exists(line_idx)) mem_model[line_idx] = rand64();
    return mem_model[line_idx];
  endfunction

  // Byte-wise view of the line starting at the access offset, then sized/extended.
  function automatic logic [63:0] extract(input logic [63:0] line, input logic [2:0] off,
                                          input logic [2:0] ldt);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = line[8*(int'(off) + i) +: 8];
    case (ldt)
      3'd0:    return 64'($signed(v[7:0]));
      3'd1:    return 64'($signed(v[15:0]));
      3'd2:    return 64'($signed(v[31:0]));
      3'd4:    return 64'(v[7:0]);
      3'd5:    return 64'(v[15:0]);
      3'd6:    return 64'(v[31:0]);
      default: return v;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] line, input logic [63:0] wd,
                                        input logic [7:0] wm);
    logic [63:0] r;
    r = line;
    for (int i = 0; i < 8; i++)
      if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t base_exp();
    exp_t e;
    e.stall = 1'b0; e.reqv = 1'b0; e.err = 1'b0;
    e.req_wen = wen_i; e.req_wdata = wdata_i;
    e.req_addr = '0; e.req_wmask = '0;
    e.rd = rd_wdata_i; e.reg_wen = reg_wen_i;
    e.rd_waddr = rd_waddr_i; e.inst_addr = inst_addr_i;
    return e;
  endfunction

  // r = cycles ready is held low in REQ; d = WAIT cycles before the response
  // (d > TMO means it never comes and the access times out).
  task automatic run_inst(input logic ren, input logic wen, input logic [2:0] ldt,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, input int r, input int d);
    logic [63:0] line, exp_ld;
    int          a, w, total, j;
    bit          to;
    exp_t        e;
    ren_i = ren; wen_i = wen; ld_type_i = ldt;
    raddr_i = (ren && !wen) ? addr : rand64();
    waddr_i = wen ? addr : rand64();
    wdata_i = wdata; wmask_i = wmask;
    rd_wdata_i = rand64(); rd_waddr_i = 5'($urandom); reg_wen_i = 1'($urandom);
    inst_addr_i = rand64();
    if (!(ren || wen)) begin
      dmem_req_ready_i = 1'($urandom); dmem_resp_valid_i = 1'($urandom);
      dmem_resp_rdata_i = rand64();
      drive_cycle(base_exp());
      return;
    end
    line   = mem_get(addr[63:3]);
    to     = (d > TMO);
    a      = r + 1;
    w      = to ? TMO + 1 : d + 1;
    total  = a + w + 2;
    exp_ld = to ? 64'd0 : extract(line, addr[2:0], ldt);
    for (int k = 0; k < total; k++) begin
      if (k >= 1 && k <= r)  dmem_req_ready_i = 1'b0;
      else if (k == r + 1)   dmem_req_ready_i = 1'b1;
      else                   dmem_req_ready_i = 1'($urandom);
      dmem_resp_rdata_i = rand64();
      if (k >= a + 1 && k <= a + w) begin
        j = k - 1 - a;
        dmem_resp_valid_i = (!to && j == d);
        if (!to && j == d) dmem_resp_rdata_i = line;
      end else begin
        dmem_resp_valid_i = 1'($urandom);
      end
      e           = base_exp();
      e.stall     = (k < total - 1);
      e.reqv      = (k >= 1 && k <= a);
      e.req_addr  = {addr[63:3], 3'b000};
      e.req_wmask = wen ? wmask : 8'h00;
      e.err       = to && (k == total - 1);
      e.rd        = (k == total - 1 && ren && !wen) ? exp_ld : rd_wdata_i;
      e.reg_wen   = reg_wen_i & ~e.stall;
      drive_cycle(e);
    end
    if (wen && !to) mem_model[addr[63:3]] = merge(line, wdata, wmask);
  endtask

  task automatic idle_inputs();
    ren_i = 0; wen_i = 0; ld_type_i = 0; raddr_i = 0; waddr_i = 0; wdata_i = 0;
    wmask_i = 0; rd_wdata_i = 0; rd_waddr_i = 0; reg_wen_i = 0; inst_addr_i = 0;
    dmem_req_ready_i = 0; dmem_resp_valid_i = 0; dmem_resp_rdata_i = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    e = base_exp();
    drive_cycle(e);
    rst = 1'b0;

    // Model pins: hand-computed load results.
    chk("model_lb", extract(64'h00000000_80FF0000, 3'd3, 3'd0), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_lhu", extract(64'hABCD_0000_0000_0000, 3'd6, 3'd5), 64'h0000_0000_0000_ABCD);
    chk("model_ld_tail", extract(64'h1122_3344_5566_7788, 3'd5, 3'd3), 64'h0000_0000_0011_2233);

    // Non-memory op passes through with no stall.
    run_inst(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 8'd0, 0, 0);
    // LB, zero-wait memory.
    mem_model[61'h1000 >> 3] = 64'h00000000_80FF0000;
    run_inst(1'b1, 1'b0, 3'd0, 64'h1003, 64'd0, 8'd0, 0, 0);
    // SD with ready held low for two cycles.
    run_inst(1'b0, 1'b1, 3'd3, 64'h2008, 64'hDEAD_BEEF_0000_0001, 8'hFF, 2, 0);
    // LHU from the top half-word.
    mem_model[61'h3000 >> 3] = 64'hABCD_0000_0000_0000;
    run_inst(1'b1, 1'b0, 3'd5, 64'h3006, 64'd0, 8'd0, 0, 0);
    // Response never arrives: timeout.
    run_inst(1'b1, 1'b0, 3'd2, 64'h3004, 64'd0, 8'd0, 1, TMO + 20);
    // Response on the last allowed WAIT cycle still completes normally.
    run_inst(1'b1, 1'b0, 3'd3, 64'h2008, 64'd0, 8'd0, 0, TMO);
    // Store and load together: the store wins.
    run_inst(1'b1, 1'b1, 3'd0, 64'h2010, 64'h0102_0304_0506_0708, 8'h0F, 1, 1);

    // Reset while in WAIT, response arrives the cycle after.
    ren_i = 1; wen_i = 0; ld_type_i = 3'd3; raddr_i = 64'h4000;
    rd_wdata_i = 64'h55; reg_wen_i = 1; rd_waddr_i = 5'd7; inst_addr_i = 64'h80;
    dmem_req_ready_i = 0; dmem_resp_valid_i = 0;
    e = base_exp(); e.stall = 1; e.reg_wen = 0; drive_cycle(e);
    dmem_req_ready_i = 1;
    e = base_exp(); e.stall = 1; e.reqv = 1; e.req_addr = 64'h4000;
    e.req_wmask = 0; e.reg_wen = 0; drive_cycle(e);
    dmem_req_ready_i = 0; rst = 1;
    e = base_exp(); e.stall = 1; e.reg_wen = 0; drive_cycle(e);
    rst = 0; ren_i = 0; dmem_resp_valid_i = 1; dmem_req_ready_i = 1;
    dmem_resp_rdata_i = 64'hFFFF;
    e = base_exp(); drive_cycle(e);
    dmem_resp_valid_i = 0;
    e = base_exp(); drive_cycle(e);

    // Random traffic over a small address window so loads hit earlier stores.
    for (int n = 0; n < 250; n++) begin
      int          kind;
      logic [63:0] addr;
      kind = $urandom_range(0, 9);
      addr = 64'h5000 + 64'($urandom_range(0, 63));
      case (kind)
        0, 1:    run_inst(1'b0, 1'b0, 3'd0, addr, 64'd0, 8'd0, 0, 0);
        2, 3, 4, 5:
                 run_inst(1'b1, 1'b0, 3'($urandom), addr, rand64(), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, TMO + 2));
        6, 7, 8: run_inst(1'b0, 1'b1, 3'($urandom), addr, rand64(), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, TMO + 2));
        default: run_inst(1'b1, 1'b1, 3'($urandom), addr, rand64(), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, TMO + 2));
      endcase
    end

    idle_inputs();
    drive_cycle(base_exp());
    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
